// File: rtl/exe_mem_pkg.sv
// Shared encodings and helpers for the EXE-stage memory request unit.
package exe_mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Byte strobes on an 8-lane view; 32-bit callers pass lane[2]=0 and keep the low half.
    function automatic logic [7:0] gen_wstrb(input logic [1:0] size, input logic [2:0] lane);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << lane;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lo,
                                           input logic dword_ok);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return lo[0];
            SZ_W:    return |lo[1:0];
            default: return ~dword_ok | (|lo);
        endcase
    endfunction

endpackage

// File: rtl/outst_fifo.sv
// Tracks accepted-but-unanswered bus requests; each entry carries only a cancel flag.
module outst_fifo #(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic          push_cancel,
    input  logic          pop,
    input  logic          cancel_all,
    output logic          head_cancel,
    output logic          empty,
    output logic [CW-1:0] cnt
);

    logic [DEPTH-1:0] cancel_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_eff;
    logic             pop_eff;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty       = (cnt == '0);
    assign pop_eff     = pop & ~empty;
    assign push_eff    = push & ((cnt != CW'(DEPTH)) | pop_eff);
    assign head_cancel = cancel_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cancel_q <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
        end else begin
            if (cancel_all)
                cancel_q <= '1;
            if (push_eff) begin
                cancel_q[wr_ptr] <= push_cancel | cancel_all;
                wr_ptr           <= wrap_inc(wr_ptr);
            end
            if (pop_eff)
                rd_ptr <= wrap_inc(rd_ptr);
            if (push_eff & ~pop_eff)
                cnt <= cnt + CW'(1);
            else if (~push_eff & pop_eff)
                cnt <= cnt - CW'(1);
        end
    end

    // A response with nothing outstanding is a bus protocol violation.
    assert property (@(posedge clk) disable iff (!resetn) !(pop && empty));

endmodule

// File: rtl/exe_mem_req_unit.sv
// EXE-stage load/store issue: strobes, replicated write data, ALE check and
// request/addr_ok/data_ok bus handshake with outstanding-response tracking.
module exe_mem_req_unit
    import exe_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_OUTST = 2,
    localparam int unsigned CW = $clog2(MAX_OUTST + 1),
    localparam int unsigned SW = DATA_W / 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_mem,
    input  logic              in_is_st,
    input  logic [1:0]        in_size,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              in_ex,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_ale,
    output logic              out_req_sent,
    output logic [2:0]        out_addr_low,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [SW-1:0]     data_wstrb,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    output logic              resp_drop,
    output logic [CW-1:0]     outst_cnt
);

    state_e            state_q;
    state_e            state_d;
    logic              stage_valid;
    logic              flush_seen;
    logic              mem_q;
    logic              st_q;
    logic              ex_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              ale;
    logic              need_req;
    logic              flush_any;
    logic              can_issue;
    logic              accept;
    logic              fire;
    logic              silent;
    logic              push;
    logic              head_cancel;
    logic              fifo_empty;
    logic [2:0]        lane;
    logic [7:0]        strb8;
    logic [DATA_W-1:0] wdata_rep;

    assign flush_any = flush | flush_seen;
    assign ale       = mem_q & is_misaligned(size_q, addr_q[2:0], DATA_W == 64);
    assign need_req  = stage_valid & mem_q & ~ex_q & ~ale & ~flush_seen;
    // A pop in this cycle frees a slot even though the count still reads full.
    assign can_issue = (outst_cnt < CW'(MAX_OUTST)) | data_data_ok;

    assign out_valid    = stage_valid & ~flush_any
                        & ((state_q == ST_DONE) | ((state_q == ST_IDLE) & ~need_req));
    assign out_req_sent = (state_q == ST_DONE) & ~flush_any;
    assign out_ale      = ale;
    assign out_addr_low = addr_q[2:0];
    assign in_ready     = ~stage_valid | (out_valid & out_ready);

    assign accept = in_valid & in_ready;
    assign fire   = out_valid & out_ready;
    // Flushed instructions leave quietly, but never while a request is still unaccepted.
    assign silent = stage_valid & flush_any & ((state_q != ST_REQ) | data_addr_ok);

    assign lane       = (DATA_W == 64) ? addr_q[2:0] : {1'b0, addr_q[1:0]};
    assign strb8      = gen_wstrb(size_q, lane);
    assign data_req   = (state_q == ST_REQ);
    assign data_wr    = st_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wstrb = st_q ? strb8[SW-1:0] : '0;
    assign data_wdata = wdata_rep;
    assign resp_drop  = data_data_ok & ~fifo_empty & head_cancel;

    always_comb begin
        case (size_q)
            SZ_B:    wdata_rep = {(DATA_W / 8){wdata_q[7:0]}};
            SZ_H:    wdata_rep = {(DATA_W / 16){wdata_q[15:0]}};
            SZ_W:    wdata_rep = {(DATA_W / 32){wdata_q[31:0]}};
            default: wdata_rep = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: if (need_req & ~flush & can_issue) state_d = ST_REQ;
            ST_REQ: begin
                if (data_addr_ok) begin
                    push    = 1'b1;
                    state_d = flush_any ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: if (flush_any | out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (accept)
            state_d = ST_IDLE;
    end

    // Instruction holding register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stage_valid <= 1'b0;
            flush_seen  <= 1'b0;
            mem_q       <= 1'b0;
            st_q        <= 1'b0;
            ex_q        <= 1'b0;
            size_q      <= SZ_B;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else if (accept) begin
            stage_valid <= ~flush;
            flush_seen  <= 1'b0;
            mem_q       <= in_is_mem;
            st_q        <= in_is_st;
            ex_q        <= in_ex;
            size_q      <= in_size;
            addr_q      <= in_addr;
            wdata_q     <= in_wdata;
        end else if (fire | silent) begin
            stage_valid <= 1'b0;
            flush_seen  <= 1'b0;
        end else if (flush & stage_valid) begin
            flush_seen <= 1'b1;
        end
    end

    outst_fifo #(.DEPTH(MAX_OUTST)) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push        (push),
        .push_cancel (flush_any),
        .pop         (data_data_ok),
        .cancel_all  (flush),
        .head_cancel (head_cancel),
        .empty       (fifo_empty),
        .cnt         (outst_cnt)
    );

endmodule

// File: doc/exe_mem_req_unit.md
Name: exe_mem_req_unit

Overview:
- Parametrised EXE-stage memory-access unit.
- Takes one decoded load/store per handshake, computes byte strobes and aligned write data, and checks address alignment (ALE).
- Drives a request/addr_ok/data_ok memory bus and tracks up to MAX_OUTST accepted-but-unanswered requests, so MEM can match or discard responses.
- Sits between ID/EXE issue and the MEM stage; replaces the fixed single-cycle SRAM-enable path.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be 32 or 64.
- MAX_OUTST, 2, max outstanding accepted requests; ≥1; count width CW = clog2(MAX_OUTST+1).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  unit can accept instruction
- in_is_mem  in  1  instruction is load/store
- in_is_st  in  1  1=store, 0=load
- in_size  in  2  0=byte, 1=half, 2=word, 3=dword (only legal if DATA_W=64)
- in_addr  in  ADDR_W  effective address
- in_wdata  in  DATA_W  store source (low bytes significant)
- in_ex  in  1  upstream exception already pending
- flush  in  1  WB exception/ertn flush
- out_valid  out  1  result to MEM valid
- out_ready  in  1  MEM accepts
- out_ale  out  1  alignment exception for this instruction
- out_req_sent  out  1  instruction owns one outstanding response
- out_addr_low  out  3  addr[2:0] for MEM load extraction
- data_req  out  1  bus request
- data_wr  out  1  write
- data_size  out  2  size
- data_addr  out  ADDR_W  address, low bits unmasked
- data_wstrb  out  DATA_W/8  byte strobes
- data_wdata  out  DATA_W  replicated write data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response returned
- resp_drop  out  1  current data_ok belongs to a cancelled request; MEM discards it
- outst_cnt  out  CW  outstanding requests

Behaviour:
- Reset: stage_valid=0, state=IDLE, FIFO empty, outst_cnt=0. Outputs: data_req=0, out_valid=0, resp_drop=0, in_ready=1.
- Capture: on in_valid & in_ready, latch all in_* fields; stage_valid<=1.
- in_ready = ~stage_valid | (out_valid & out_ready).
- ALE: misaligned iff addr[size-1:0]!=0, i.e. half: a[0]; word: a[1:0]; dword: a[2:0]. size=3 with DATA_W=32 also sets ale.
- need_req = stage_valid & is_mem & ~in_ex & ~ale & ~flush_seen.
- FSM IDLE:
  - need_req & (outst_cnt<MAX_OUTST) -> REQ.
  - otherwise, a non-mem, excepting, or flushed instruction goes straight to DONE-equivalent: out_valid=1, out_req_sent=0.
- FSM REQ:
  - data_req=1; addr/size/wstrb/wdata held stable.
  - Stays in REQ until data_addr_ok, even if flush arrives; a request is never withdrawn.
  - On addr_ok: push FIFO entry {cancel = flush | flush_seen}; -> DONE.
- FSM DONE:
  - out_valid=1, out_req_sent=1 unless cancelled.
  - On out_ready -> IDLE, or capture the next instruction in the same cycle.
- flush:
  - Sets flush_seen for the held instruction. out_valid is forced 0 that cycle and afterwards; the instruction retires silently once any REQ completes.
  - Marks every FIFO entry cancel=1.
  - A capture in the flush cycle is suppressed (stage_valid<=0).
- wstrb: byte lanes selected by size and addr low bits; byte=1 lane, half=2, word=4, dword=all. Zero for loads.
- wdata: source replicated across lanes (byte x8/x4, half x4/x2, word x2).
- Tracking FIFO (depth MAX_OUTST, pointer wrap modulo depth):
  - data_ok pops the head; resp_drop = data_ok & head.cancel.
  - Simultaneous push and pop: count unchanged.
  - data_ok with empty FIFO is a protocol error; it is ignored and flagged by an assertion.
- Full: when outst_cnt==MAX_OUTST, data_req stays low until a pop, including a pop in the same cycle (req is registered, so it asserts the next cycle).
- Reset mid-operation clears everything. The bus is assumed to be reset together with this unit.

Decomposition:
- Package exe_mem_pkg: size encodings (SZ_B/H/W/D), FSM state enum, function for wstrb generation and function for ALE check.
- One sub-module: outst_fifo (parametrised depth, 1-bit cancel payload, bulk-cancel input, count output).

Test Plan:
- Word load, addr 0x1004, addr_ok after 2 cycles, data_ok 1 cycle later -> data_req high 3 cycles; wstrb=0; out_valid after addr_ok; outst_cnt 0→1→0; resp_drop=0.
- Byte store, addr 0x2003, wdata 0xAB, addr_ok immediate -> wstrb=4'b1000; data_wdata=0xABABABAB; data_wr=1.
- Half load at 0x3001 -> out_ale=1; no data_req; out_valid the next cycle; out_req_sent=0.
- MAX_OUTST=2; three back-to-back loads with data_ok withheld -> third data_req stays 0 until the first data_ok; then it asserts the next cycle.
- flush while in REQ before addr_ok -> data_req stays high until addr_ok; entry cancel=1; later data_ok gives resp_drop=1; no out_valid.
- DATA_W=64, dword store at 0x8 -> wstrb=8'hFF. At addr 0x4 -> ale=1, no request.
